// File: rtl/hiscore_if.sv
`default_nettype none
// ============================================================================
// Module   : hiscore_if
// Purpose  : Game-control and display bundle between a game host and hiscore_ctrl
// Revision : 1.0 - initial release
// ============================================================================
interface hiscore_if #(
  parameter int SCORE_W = 11
);
  logic               start;
  logic               score_inc;
  logic               game_over;
  logic [1:0]         sel;
  logic               busy;
  logic [1:0]         new_rank;
  logic [1:0]         disp_idx;
  logic [SCORE_W-1:0] disp_val;
  logic [SCORE_W-1:0] first;
  logic [SCORE_W-1:0] second;
  logic [SCORE_W-1:0] third;

  modport master (
    output start, score_inc, game_over, sel,
    input  busy, new_rank, disp_idx, disp_val, first, second, third
  );

  modport slave (
    input  start, score_inc, game_over, sel,
    output busy, new_rank, disp_idx, disp_val, first, second, third
  );
endinterface
`default_nettype wire

// File: rtl/hiscore_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hiscore_ctrl
// Purpose  : Score counter with a three-entry high-score table; define
//            HISCORE_AUTOROTATE_EN to auto-rotate the display in SHOW.
// Revision : 1.0 - initial release
// ============================================================================
module hiscore_ctrl #(
  parameter int SCORE_W = 11,
  parameter int ROT_CNT = 25000000
) (
  input  logic      clk,
  input  logic      rst,
  hiscore_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PLAY   = 3'd1,
    S_INSERT = 3'd2,
    S_SHIFT  = 3'd3,
    S_SHOW   = 3'd4
  } state_t;

  localparam logic [SCORE_W-1:0] c_score_max = '1;

  state_t             r_state;
  logic [SCORE_W-1:0] r_curr;
  logic [SCORE_W-1:0] r_first;
  logic [SCORE_W-1:0] r_second;
  logic [SCORE_W-1:0] r_third;
  logic [SCORE_W-1:0] r_disp_val;
  logic [1:0]         r_disp_idx;
  logic [1:0]         r_rank;
  logic [1:0]         r_new_rank;
  logic               r_busy;

`ifdef HISCORE_AUTOROTATE_EN
  localparam int CNT_W = (ROT_CNT > 1) ? $clog2(ROT_CNT) : 1;
  localparam logic [CNT_W-1:0] c_rot_last = CNT_W'(ROT_CNT - 1);
  logic [CNT_W-1:0] r_rot_cnt;
  logic [1:0]       r_rot_idx;
`endif

  logic [SCORE_W-1:0] w_inc_score;
  logic [1:0]         w_rank;
  logic [1:0]         w_src_idx;
  logic [SCORE_W-1:0] w_src_val;

  // Saturating increment; also used on the game_over cycle so a coincident
  // point is counted before insertion.
  always_comb begin
    w_inc_score = r_curr;
    if (bus.score_inc && (r_curr != c_score_max)) begin
      w_inc_score = r_curr + 1'b1;
    end
  end

  // Strict compare: ties land below the existing entry and 0 never enters.
  always_comb begin
    w_rank = 2'd0;
    if (r_curr > r_first) begin
      w_rank = 2'd1;
    end else if (r_curr > r_second) begin
      w_rank = 2'd2;
    end else if (r_curr > r_third) begin
      w_rank = 2'd3;
    end
  end

  always_comb begin
`ifdef HISCORE_AUTOROTATE_EN
    w_src_idx = r_rot_idx;
`else
    w_src_idx = bus.sel;
`endif
    case (w_src_idx)
      2'd1:    w_src_val = r_first;
      2'd2:    w_src_val = r_second;
      2'd3:    w_src_val = r_third;
      default: w_src_val = r_curr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_curr     <= '0;
      r_first    <= '0;
      r_second   <= '0;
      r_third    <= '0;
      r_disp_val <= '0;
      r_disp_idx <= 2'd0;
      r_rank     <= 2'd0;
      r_new_rank <= 2'd0;
      r_busy     <= 1'b0;
`ifdef HISCORE_AUTOROTATE_EN
      r_rot_cnt  <= '0;
      r_rot_idx  <= 2'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_disp_idx <= 2'd0;
          r_disp_val <= r_curr;
          if (bus.start) begin
            r_state    <= S_PLAY;
            r_curr     <= '0;
            r_new_rank <= 2'd0;
          end
        end

        S_PLAY: begin
          r_disp_idx <= 2'd0;
          r_disp_val <= r_curr;
          r_curr     <= w_inc_score;
          if (bus.game_over) begin
            r_state <= S_INSERT;
            r_busy  <= 1'b1;
          end
        end

        S_INSERT: begin
          r_rank  <= w_rank;
          r_state <= S_SHIFT;
        end

        S_SHIFT: begin
          case (r_rank)
            2'd1: begin
              r_third  <= r_second;
              r_second <= r_first;
              r_first  <= r_curr;
            end
            2'd2: begin
              r_third  <= r_second;
              r_second <= r_curr;
            end
            2'd3: begin
              r_third <= r_curr;
            end
            default: ;
          endcase
          r_new_rank <= r_rank;
          r_busy     <= 1'b0;
          r_state    <= S_SHOW;
`ifdef HISCORE_AUTOROTATE_EN
          r_rot_cnt  <= '0;
          r_rot_idx  <= 2'd0;
`endif
        end

        S_SHOW: begin
          r_disp_idx <= w_src_idx;
          r_disp_val <= w_src_val;
`ifdef HISCORE_AUTOROTATE_EN
          if (r_rot_cnt == c_rot_last) begin
            r_rot_cnt <= '0;
            r_rot_idx <= r_rot_idx + 2'd1;
          end else begin
            r_rot_cnt <= r_rot_cnt + 1'b1;
          end
`endif
          if (bus.start) begin
            r_state    <= S_PLAY;
            r_curr     <= '0;
            r_new_rank <= 2'd0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.new_rank = r_new_rank;
  assign bus.disp_idx = r_disp_idx;
  assign bus.disp_val = r_disp_val;
  assign bus.first    = r_first;
  assign bus.second   = r_second;
  assign bus.third    = r_third;

endmodule
`default_nettype wire

// File: tb/tb_hiscore_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hiscore_ctrl
// Purpose  : Directed self-checking bench for hiscore_ctrl (default and
//            HISCORE_AUTOROTATE_EN builds)
// Revision : 1.0 - initial release
// ============================================================================
module tb_hiscore_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hiscore_if #(.SCORE_W(11)) bus ();
  hiscore_if #(.SCORE_W(3))  bus3 ();

  hiscore_ctrl #(.SCORE_W(11), .ROT_CNT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  hiscore_ctrl #(.SCORE_W(3), .ROT_CNT(4)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start a game, add n points, end it, and return on the first SHOW cycle.
  task automatic play_game(input int n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    if (n > 0) begin
      bus.score_inc = 1'b1;
      tick(n);
      bus.score_inc = 1'b0;
    end
    bus.game_over = 1'b1;
    tick();
    bus.game_over = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    total++;
    if ({bus.first, bus.second, bus.third} !== 33'd0) begin
      bad++;
      $display("FAIL reset_table: got %0d/%0d/%0d expected 0/0/0", bus.first, bus.second, bus.third);
    end
    total++;
    if (bus.disp_val !== 11'd0 || bus.disp_idx !== 2'd0) begin
      bad++;
      $display("FAIL reset_disp: got val=%0d idx=%0d expected 0/0", bus.disp_val, bus.disp_idx);
    end
    total++;
    if (bus.busy !== 1'b0 || bus.new_rank !== 2'd0) begin
      bad++;
      $display("FAIL reset_flags: got busy=%0b rank=%0d expected 0/0", bus.busy, bus.new_rank);
    end
  endtask

  task automatic test_first_game();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.score_inc = 1'b1;
    tick(5);
    bus.score_inc = 1'b0;
    tick();
    total++;
    if (bus.disp_val !== 11'd5 || bus.disp_idx !== 2'd0) begin
      bad++;
      $display("FAIL play_disp: got val=%0d idx=%0d expected 5/0", bus.disp_val, bus.disp_idx);
    end
    bus.game_over = 1'b1;
    tick();
    bus.game_over = 1'b0;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_n1: got %0b expected 1", bus.busy);
    end
    tick();
    total++;
    if (bus.busy !== 1'b1 || bus.first !== 11'd0) begin
      bad++;
      $display("FAIL busy_n2: got busy=%0b first=%0d expected 1/0", bus.busy, bus.first);
    end
    tick();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_n3: got %0b expected 0", bus.busy);
    end
    total++;
    if (bus.first !== 11'd5 || bus.second !== 11'd0 || bus.third !== 11'd0 || bus.new_rank !== 2'd1) begin
      bad++;
      $display("FAIL first_game: got %0d/%0d/%0d rank=%0d expected 5/0/0 rank=1",
               bus.first, bus.second, bus.third, bus.new_rank);
    end
  endtask

  task automatic test_saturate();
    bus3.start = 1'b1;
    tick();
    bus3.start = 1'b0;
    bus3.score_inc = 1'b1;
    tick(9);
    bus3.score_inc = 1'b0;
    tick(2);
    total++;
    if (bus3.disp_val !== 3'd7) begin
      bad++;
      $display("FAIL saturate: got %0d expected 7", bus3.disp_val);
    end
    bus3.game_over = 1'b1;
    tick();
    bus3.game_over = 1'b0;
    tick(2);
    total++;
    if (bus3.first !== 3'd7 || bus3.new_rank !== 2'd1) begin
      bad++;
      $display("FAIL sat_insert: got first=%0d rank=%0d expected 7/1", bus3.first, bus3.new_rank);
    end
    bus3.start = 1'b1;
    tick();
    bus3.start = 1'b0;
    bus3.score_inc = 1'b1;
    tick(4);
    bus3.game_over = 1'b1;
    tick();
    bus3.score_inc = 1'b0;
    bus3.game_over = 1'b0;
    tick(2);
    total++;
    if (bus3.first !== 3'd7 || bus3.second !== 3'd5 || bus3.new_rank !== 2'd2) begin
      bad++;
      $display("FAIL inc_with_go: got %0d/%0d rank=%0d expected 7/5 rank=2",
               bus3.first, bus3.second, bus3.new_rank);
    end
  endtask

  task automatic test_ranking();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    play_game(5);
    play_game(9);
    play_game(7);
    total++;
    if (bus.first !== 11'd9 || bus.second !== 11'd7 || bus.third !== 11'd5 || bus.new_rank !== 2'd2) begin
      bad++;
      $display("FAIL rank_975: got %0d/%0d/%0d rank=%0d expected 9/7/5 rank=2",
               bus.first, bus.second, bus.third, bus.new_rank);
    end
    play_game(7);
    total++;
    if (bus.first !== 11'd9 || bus.second !== 11'd7 || bus.third !== 11'd7 || bus.new_rank !== 2'd3) begin
      bad++;
      $display("FAIL rank_tie: got %0d/%0d/%0d rank=%0d expected 9/7/7 rank=3",
               bus.first, bus.second, bus.third, bus.new_rank);
    end
  endtask

  task automatic test_zero_game();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    total++;
    if (bus.new_rank !== 2'd0) begin
      bad++;
      $display("FAIL rank_clear: got %0d expected 0", bus.new_rank);
    end
    bus.game_over = 1'b1;
    tick();
    bus.game_over = 1'b0;
    tick(2);
    total++;
    if (bus.first !== 11'd9 || bus.second !== 11'd7 || bus.third !== 11'd7 || bus.new_rank !== 2'd0) begin
      bad++;
      $display("FAIL zero_game: got %0d/%0d/%0d rank=%0d expected 9/7/7 rank=0",
               bus.first, bus.second, bus.third, bus.new_rank);
    end
  endtask

  task automatic test_ignored();
    bus.score_inc = 1'b1;
    bus.game_over = 1'b1;
    tick();
    bus.score_inc = 1'b0;
    bus.game_over = 1'b0;
    tick();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL go_in_show: got busy=%0b expected 0", bus.busy);
    end
    // A mid-game start must not restart the score: 3 + 5 = 8 ranks second.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.score_inc = 1'b1;
    tick(3);
    bus.score_inc = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.score_inc = 1'b1;
    tick(5);
    bus.score_inc = 1'b0;
    bus.game_over = 1'b1;
    tick();
    bus.game_over = 1'b0;
    tick(2);
    total++;
    if (bus.first !== 11'd9 || bus.second !== 11'd8 || bus.third !== 11'd7 || bus.new_rank !== 2'd2) begin
      bad++;
      $display("FAIL start_in_play: got %0d/%0d/%0d rank=%0d expected 9/8/7 rank=2",
               bus.first, bus.second, bus.third, bus.new_rank);
    end
  endtask

  task automatic test_reset_in_shift();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.score_inc = 1'b1;
    tick(10);
    bus.score_inc = 1'b0;
    bus.game_over = 1'b1;
    tick();
    bus.game_over = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({bus.first, bus.second, bus.third} !== 33'd0 || bus.busy !== 1'b0 || bus.new_rank !== 2'd0) begin
      bad++;
      $display("FAIL rst_shift: got %0d/%0d/%0d busy=%0b rank=%0d expected 0/0/0 busy=0 rank=0",
               bus.first, bus.second, bus.third, bus.busy, bus.new_rank);
    end
    bus.score_inc = 1'b1;
    bus.game_over = 1'b1;
    tick();
    bus.score_inc = 1'b0;
    bus.game_over = 1'b0;
    tick();
    total++;
    if (bus.busy !== 1'b0 || bus.disp_val !== 11'd0) begin
      bad++;
      $display("FAIL idle_after_rst: got busy=%0b val=%0d expected 0/0", bus.busy, bus.disp_val);
    end
  endtask

  task automatic test_display();
    play_game(6);
    play_game(4);
`ifdef HISCORE_AUTOROTATE_EN
    tick();
    total++;
    if (bus.disp_idx !== 2'd0 || bus.disp_val !== 11'd4) begin
      bad++;
      $display("FAIL rot_0: got idx=%0d val=%0d expected 0/4", bus.disp_idx, bus.disp_val);
    end
    tick(3);
    total++;
    if (bus.disp_idx !== 2'd0) begin
      bad++;
      $display("FAIL rot_hold: got idx=%0d expected 0", bus.disp_idx);
    end
    tick();
    total++;
    if (bus.disp_idx !== 2'd1 || bus.disp_val !== 11'd6) begin
      bad++;
      $display("FAIL rot_1: got idx=%0d val=%0d expected 1/6", bus.disp_idx, bus.disp_val);
    end
    tick(4);
    total++;
    if (bus.disp_idx !== 2'd2 || bus.disp_val !== 11'd4) begin
      bad++;
      $display("FAIL rot_2: got idx=%0d val=%0d expected 2/4", bus.disp_idx, bus.disp_val);
    end
    tick(4);
    total++;
    if (bus.disp_idx !== 2'd3 || bus.disp_val !== 11'd0) begin
      bad++;
      $display("FAIL rot_3: got idx=%0d val=%0d expected 3/0", bus.disp_idx, bus.disp_val);
    end
    tick(4);
    total++;
    if (bus.disp_idx !== 2'd0) begin
      bad++;
      $display("FAIL rot_wrap: got idx=%0d expected 0", bus.disp_idx);
    end
`else
    bus.sel = 2'd1;
    tick();
    total++;
    if (bus.disp_idx !== 2'd1 || bus.disp_val !== 11'd6) begin
      bad++;
      $display("FAIL sel_1: got idx=%0d val=%0d expected 1/6", bus.disp_idx, bus.disp_val);
    end
    bus.sel = 2'd2;
    tick();
    total++;
    if (bus.disp_idx !== 2'd2 || bus.disp_val !== 11'd4) begin
      bad++;
      $display("FAIL sel_2: got idx=%0d val=%0d expected 2/4", bus.disp_idx, bus.disp_val);
    end
    bus.sel = 2'd3;
    tick();
    total++;
    if (bus.disp_idx !== 2'd3 || bus.disp_val !== 11'd0) begin
      bad++;
      $display("FAIL sel_3: got idx=%0d val=%0d expected 3/0", bus.disp_idx, bus.disp_val);
    end
    bus.sel = 2'd0;
    tick();
`endif
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.score_inc  = 1'b0;
    bus.game_over  = 1'b0;
    bus.sel        = 2'd0;
    bus3.start     = 1'b0;
    bus3.score_inc = 1'b0;
    bus3.game_over = 1'b0;
    bus3.sel       = 2'd0;

    test_reset();
    test_first_game();
    test_saturate();
    test_ranking();
    test_zero_game();
    test_ignored();
    test_reset_in_shift();
    test_display();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hiscore_ctrl.md
HISCORE_CTRL -- requirements
Module: hiscore_ctrl

Interface
REQ-001 Parameter SCORE_W, default 11, width of the score and of every table entry.
REQ-002 Parameter ROT_CNT, default 25000000, number of clk cycles each entry is displayed during auto-rotation.
REQ-003 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port start  input  1  one-cycle pulse that begins a new game.
REQ-006 Port score_inc  input  1  one-cycle pulse that adds one point to the current score.
REQ-007 Port game_over  input  1  one-cycle pulse that ends the game and requests table insertion.
REQ-008 Port sel  input  2  manual display select: 0 current, 1 first, 2 second, 3 third.
REQ-009 Port busy  output  1  high while in INSERT or SHIFT.
REQ-010 Port new_rank  output  2  rank won by the last finished game (0 none, 1-3 place); held until the next start.
REQ-011 Port disp_idx  output  2  index of the value on disp_val (same encoding as sel).
REQ-012 Port disp_val  output  SCORE_W  selected value, registered.
REQ-013 Ports first, second, third  output  SCORE_W each  high-score table, non-increasing order.

Function
REQ-014 FSM states: IDLE, PLAY, INSERT, SHIFT, SHOW.
- IDLE -start-> PLAY
- PLAY -game_over-> INSERT
- INSERT -> SHIFT (unconditional)
- SHIFT -> SHOW (unconditional)
- SHOW -start-> PLAY
REQ-015 On entering PLAY, curr_score is cleared to 0 and new_rank is cleared to 0.
REQ-016 In PLAY, each score_inc adds 1 to curr_score; curr_score saturates at 2^SCORE_W-1.
REQ-017 score_inc and game_over in the same PLAY cycle: the increment is counted before insertion.
REQ-018 score_inc outside PLAY is ignored.
REQ-019 game_over outside PLAY is ignored.
REQ-020 start in PLAY, INSERT or SHIFT is ignored.
REQ-021 In INSERT, rank is computed against the table using strict greater-than.
- rank 1 if curr_score > first, else 2 if > second, else 3 if > third, else 0.
- Ties rank below the existing entry; a score of 0 never enters the table.
REQ-022 In SHIFT, the table is updated according to rank; new_rank is loaded with rank in the same cycle.
- rank 1: third<=second, second<=first, first<=score.
- rank 2: third<=second, second<=score.
- rank 3: third<=score.
- rank 0: table unchanged.
REQ-023 Latency: game_over accepted in cycle N gives busy high in N+1 and N+2, the updated table visible in N+3, and state SHOW in N+3.
REQ-024 disp_val and disp_idx are registered one cycle after their selection source.
- In IDLE and PLAY, disp_idx = 0 and disp_val = curr_score.
- In INSERT and SHIFT, both hold their previous values.
- In SHOW, the selection follows REQ-030/031.

Reset
REQ-025 rst, sampled high on a rising clk edge, forces state IDLE from any state, including mid-INSERT or mid-SHIFT.
REQ-026 On reset, curr_score, first, second, third, disp_val, new_rank, disp_idx and the rotation counter are all cleared to 0, and busy is 0.
REQ-027 A reset asserted during SHIFT discards the pending table update.

Configuration
REQ-028 Macro HISCORE_AUTOROTATE_EN selects the SHOW-state display source.
REQ-029 The macro affects only SHOW-state display selection; all other behaviour is identical in both builds.
REQ-030 With the macro defined, in SHOW disp_idx cycles 0,1,2,3,0,... advancing every ROT_CNT cycles, starting at 0 on SHOW entry; sel is ignored.
REQ-031 With the macro undefined, in SHOW disp_idx = sel; no rotation counter is built.

Verification
REQ-032 Reset, start, 5 score_inc, game_over -> busy high 2 cycles; first=5, second=0, third=0, new_rank=1.
REQ-033 Play games scoring 5, 9, 7, then 7 -> table 9,7,5 then 9,7,7 (the tie ranks third); new_rank=3 after the last game.
REQ-034 Play a game scoring 0 -> table unchanged, new_rank=0.
REQ-035 With SCORE_W=3, 9 score_inc -> curr_score saturates at 7; score_inc coinciding with game_over at score 4 inserts 5.
REQ-036 rst asserted in the SHIFT cycle of a rank-1 game -> all table entries read 0 and state is IDLE.
REQ-037 Both builds, with ROT_CNT=4, in SHOW:
- macro defined: disp_idx steps 0,1,2,3 every 4 cycles.
- macro undefined: sel=2 gives disp_val=second on the next cycle.
